// File: rtl/id_ex_if.sv
// ID/EX pipeline bundle: decoded fields coming from ID and the registered copies presented to EX.
// The master side drives the decode fields and the slave (the stage register) drives the EX copies.
interface id_ex_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rs1;
    logic [4:0]      in_rs2;
    logic [4:0]      in_rd;
    logic            in_uses_rs1;
    logic            in_uses_rs2;
    logic [XLEN-1:0] in_rs1_data;
    logic [XLEN-1:0] in_rs2_data;
    logic [XLEN-1:0] in_imm;
    logic            in_reg_write;
    logic            in_mem_read;
    logic            in_mem_write;
    logic            in_alu_src;
    logic [3:0]      in_alu_op;

    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_mem_read;
    logic            ex_mem_write;
    logic            ex_alu_src;
    logic [3:0]      ex_alu_op;

    modport master (
        output in_valid, in_pc, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
               in_rs1_data, in_rs2_data, in_imm, in_reg_write, in_mem_read,
               in_mem_write, in_alu_src, in_alu_op,
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op
    );

    modport slave (
        input  in_valid, in_pc, in_rs1, in_rs2, in_rd, in_uses_rs1, in_uses_rs2,
               in_rs1_data, in_rs2_data, in_imm, in_reg_write, in_mem_read,
               in_mem_write, in_alu_src, in_alu_op,
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
               ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src, ex_alu_op
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion and a
// saturating count of the load-use bubbles inserted.
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    id_ex_if.slave           bus,
    input  logic             flush,
    input  logic             ext_stall,
    output logic             load_use_hazard,
    output logic             if_id_stall,
    output logic [CNT_W-1:0] bubble_cnt
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            alu_src;
        logic [3:0]      alu_op;
    } ex_t;

    ex_t              ex_reg;
    ex_t              ex_next;
    ex_t              capture;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Operand sources in ID: index 0 is rs1, index 1 is rs2.
    logic [1:0]      src_uses;
    logic [1:0][4:0] src_idx;
    logic [1:0]      src_hit;

    assign src_uses = {bus.in_uses_rs2, bus.in_uses_rs1};
    assign src_idx  = {bus.in_rs2, bus.in_rs1};

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_hit[gi] = src_uses[gi] & (ex_reg.rd == src_idx[gi]);
    end

    // x0 is never a real destination, so a load into x0 cannot stall anyone.
    assign load_use_hazard = ex_reg.valid & ex_reg.mem_read & (ex_reg.rd != 5'd0)
                           & bus.in_valid & (|src_hit);
    assign if_id_stall     = ~flush & (ext_stall | load_use_hazard);

    always_comb begin
        capture           = '0;
        capture.valid     = 1'b1;
        capture.pc        = bus.in_pc;
        capture.rs1_data  = bus.in_rs1_data;
        capture.rs2_data  = bus.in_rs2_data;
        capture.imm       = bus.in_imm;
        capture.rs1       = bus.in_rs1;
        capture.rs2       = bus.in_rs2;
        capture.rd        = bus.in_rd;
        capture.reg_write = bus.in_reg_write;
        capture.mem_read  = bus.in_mem_read;
        capture.mem_write = bus.in_mem_write;
        capture.alu_src   = bus.in_alu_src;
        capture.alu_op    = bus.in_alu_op;
    end

    // Flush beats a downstream hold, which beats the load-use bubble.
    always_comb begin
        ex_next  = ex_reg;
        cnt_next = cnt_reg;
        if (flush) begin
            ex_next = '0;
        end else if (!ext_stall) begin
            if (load_use_hazard) begin
                ex_next = '0;
                if (cnt_reg != {CNT_W{1'b1}}) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end else if (bus.in_valid) begin
                ex_next = capture;
            end else begin
                ex_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_reg  <= '0;
            cnt_reg <= '0;
        end else begin
            ex_reg  <= ex_next;
            cnt_reg <= cnt_next;
        end
    end

    assign bus.ex_valid     = ex_reg.valid;
    assign bus.ex_pc        = ex_reg.pc;
    assign bus.ex_rs1_data  = ex_reg.rs1_data;
    assign bus.ex_rs2_data  = ex_reg.rs2_data;
    assign bus.ex_imm       = ex_reg.imm;
    assign bus.ex_rs1       = ex_reg.rs1;
    assign bus.ex_rs2       = ex_reg.rs2;
    assign bus.ex_rd        = ex_reg.rd;
    assign bus.ex_reg_write = ex_reg.reg_write;
    assign bus.ex_mem_read  = ex_reg.mem_read;
    assign bus.ex_mem_write = ex_reg.mem_write;
    assign bus.ex_alu_src   = ex_reg.alu_src;
    assign bus.ex_alu_op    = ex_reg.alu_op;
    assign bubble_cnt       = cnt_reg;
endmodule

// File: tb/tb_id_ex_stage.sv
// Random and directed checks of id_ex_stage against a behavioural model of the EX slot;
// a second instance with a 2-bit counter exercises bubble-count saturation.
module tb_id_ex_stage;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic ext_stall = 1'b0;
    always #5 clk = ~clk;

    id_ex_if #(.XLEN(XLEN)) bus_a ();
    id_ex_if #(.XLEN(XLEN)) bus_b ();

    assign bus_b.in_valid     = bus_a.in_valid;
    assign bus_b.in_pc        = bus_a.in_pc;
    assign bus_b.in_rs1       = bus_a.in_rs1;
    assign bus_b.in_rs2       = bus_a.in_rs2;
    assign bus_b.in_rd        = bus_a.in_rd;
    assign bus_b.in_uses_rs1  = bus_a.in_uses_rs1;
    assign bus_b.in_uses_rs2  = bus_a.in_uses_rs2;
    assign bus_b.in_rs1_data  = bus_a.in_rs1_data;
    assign bus_b.in_rs2_data  = bus_a.in_rs2_data;
    assign bus_b.in_imm       = bus_a.in_imm;
    assign bus_b.in_reg_write = bus_a.in_reg_write;
    assign bus_b.in_mem_read  = bus_a.in_mem_read;
    assign bus_b.in_mem_write = bus_a.in_mem_write;
    assign bus_b.in_alu_src   = bus_a.in_alu_src;
    assign bus_b.in_alu_op    = bus_a.in_alu_op;

    logic        haz_a, stall_a, haz_b, stall_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    id_ex_stage #(.XLEN(XLEN), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .flush(flush), .ext_stall(ext_stall),
        .load_use_hazard(haz_a), .if_id_stall(stall_a), .bubble_cnt(cnt_a)
    );
    id_ex_stage #(.XLEN(XLEN), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .flush(flush), .ext_stall(ext_stall),
        .load_use_hazard(haz_b), .if_id_stall(stall_b), .bubble_cnt(cnt_b)
    );

    // What the EX slot should hold, as a plain record of the last accepted instruction.
    typedef struct {
        bit        valid;
        bit [31:0] pc, d1, d2, imm;
        bit [4:0]  rs1, rs2, rd;
        bit        rw, mr, mw, as;
        bit [3:0]  op;
    } slot_t;

    slot_t       m;
    slot_t       empty_slot;
    int unsigned cnt16 = 0;
    int unsigned cnt2 = 0;
    bit          known = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // A dependent instruction must wait only if the slot holds a real load into a non-zero register.
    function automatic bit model_hazard();
        bit reads_it;
        reads_it = (bus_a.in_uses_rs1 && bus_a.in_rs1 == m.rd) ||
                   (bus_a.in_uses_rs2 && bus_a.in_rs2 == m.rd);
        return m.valid && m.mr && (m.rd != 0) && bus_a.in_valid && reads_it;
    endfunction

    task automatic rand_in();
        bus_a.in_valid     = 1'($urandom_range(0, 3) != 0);
        bus_a.in_pc        = $urandom;
        bus_a.in_rs1       = 5'($urandom_range(0, 3));
        bus_a.in_rs2       = 5'($urandom_range(0, 3));
        bus_a.in_rd        = 5'($urandom_range(0, 3));
        bus_a.in_uses_rs1  = 1'($urandom_range(0, 1));
        bus_a.in_uses_rs2  = 1'($urandom_range(0, 1));
        bus_a.in_rs1_data  = $urandom;
        bus_a.in_rs2_data  = $urandom;
        bus_a.in_imm       = $urandom;
        bus_a.in_reg_write = 1'($urandom_range(0, 1));
        bus_a.in_mem_read  = 1'($urandom_range(0, 1));
        bus_a.in_mem_write = 1'($urandom_range(0, 1));
        bus_a.in_alu_src   = 1'($urandom_range(0, 1));
        bus_a.in_alu_op    = 4'($urandom_range(0, 15));
        flush              = 1'b0;
        ext_stall          = 1'b0;
    endtask

    task automatic set_load(input logic [4:0] rd);
        rand_in();
        bus_a.in_valid    = 1'b1;
        bus_a.in_mem_read = 1'b1;
        bus_a.in_rd       = rd;
    endtask

    task automatic settle();
        bit h;
        #1;
        if (known) begin
            h = model_hazard();
            check("load_use_hazard", 64'(haz_a), 64'(h));
            check("if_id_stall", 64'(stall_a), 64'(!flush && (ext_stall || h)));
            check("load_use_hazard_b", 64'(haz_b), 64'(h));
            check("if_id_stall_b", 64'(stall_b), 64'(!flush && (ext_stall || h)));
        end
    endtask

    task automatic tick();
        slot_t       nx;
        int unsigned c16, c2;
        bit          h;
        h   = known && model_hazard();
        nx  = m;
        c16 = cnt16;
        c2  = cnt2;
        if (!rst_n) begin
            nx = empty_slot; c16 = 0; c2 = 0;
        end else if (flush) begin
            nx = empty_slot;
        end else if (!ext_stall) begin
            if (h) begin
                nx  = empty_slot;
                c16 = (c16 < 65535) ? c16 + 1 : c16;
                c2  = (c2 < 3) ? c2 + 1 : c2;
            end else if (bus_a.in_valid) begin
                nx = '{valid: 1'b1, pc: bus_a.in_pc, d1: bus_a.in_rs1_data,
                       d2: bus_a.in_rs2_data, imm: bus_a.in_imm, rs1: bus_a.in_rs1,
                       rs2: bus_a.in_rs2, rd: bus_a.in_rd, rw: bus_a.in_reg_write,
                       mr: bus_a.in_mem_read, mw: bus_a.in_mem_write,
                       as: bus_a.in_alu_src, op: bus_a.in_alu_op};
            end else begin
                nx = empty_slot;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        m = nx; cnt16 = c16; cnt2 = c2; known = 1'b1;
        check("ex_valid", 64'(bus_a.ex_valid), 64'(m.valid));
        check("ex_pc", 64'(bus_a.ex_pc), 64'(m.pc));
        check("ex_rs1_data", 64'(bus_a.ex_rs1_data), 64'(m.d1));
        check("ex_rs2_data", 64'(bus_a.ex_rs2_data), 64'(m.d2));
        check("ex_imm", 64'(bus_a.ex_imm), 64'(m.imm));
        check("ex_rs1", 64'(bus_a.ex_rs1), 64'(m.rs1));
        check("ex_rs2", 64'(bus_a.ex_rs2), 64'(m.rs2));
        check("ex_rd", 64'(bus_a.ex_rd), 64'(m.rd));
        check("ex_reg_write", 64'(bus_a.ex_reg_write), 64'(m.rw));
        check("ex_mem_read", 64'(bus_a.ex_mem_read), 64'(m.mr));
        check("ex_mem_write", 64'(bus_a.ex_mem_write), 64'(m.mw));
        check("ex_alu_src", 64'(bus_a.ex_alu_src), 64'(m.as));
        check("ex_alu_op", 64'(bus_a.ex_alu_op), 64'(m.op));
        check("bubble_cnt", 64'(cnt_a), 64'(cnt16));
        check("bubble_cnt_b", 64'(cnt_b), 64'(cnt2));
        check("ex_valid_b", 64'(bus_b.ex_valid), 64'(m.valid));
        check("ex_rd_b", 64'(bus_b.ex_rd), 64'(m.rd));
        $display("cyc %0d rst_n %b flush %b ext_stall %b ex_valid %b ex_rd %0d bubbles %0d/%0d",
                 cyc, rst_n, flush, ext_stall, bus_a.ex_valid, bus_a.ex_rd, cnt_a, cnt_b);
    endtask

    task automatic step();
        settle();
        tick();
    endtask

    task automatic dependent_on7();
        rand_in();
        bus_a.in_valid    = 1'b1;
        bus_a.in_mem_read = 1'b0;
        bus_a.in_rs1      = 5'd1;
        bus_a.in_uses_rs1 = 1'b0;
        bus_a.in_rs2      = 5'd7;
        bus_a.in_uses_rs2 = 1'b1;
    endtask

    initial begin
        empty_slot = '{default: '0};
        m          = empty_slot;

        // Reset held for two edges with arbitrary inputs.
        @(posedge clk); #1;
        rst_n = 1'b0; rand_in(); tick();
        rand_in(); tick();
        check("rst ex_valid", 64'(bus_a.ex_valid), 64'd0);
        check("rst bubble_cnt", 64'(cnt_a), 64'd0);
        settle();
        check("rst hazard", 64'(haz_a), 64'd0);
        check("rst stall", 64'(stall_a), 64'd0);

        // Normal capture, one cycle latency.
        rst_n = 1'b1;
        rand_in();
        bus_a.in_valid = 1'b1; bus_a.in_rd = 5'd5; bus_a.in_rs1 = 5'd3;
        bus_a.in_alu_op = 4'h2; bus_a.in_imm = 32'h10; bus_a.in_mem_read = 1'b0;
        settle();
        check("normal stall", 64'(stall_a), 64'd0);
        tick();
        check("normal ex_valid", 64'(bus_a.ex_valid), 64'd1);
        check("normal ex_rd", 64'(bus_a.ex_rd), 64'd5);
        check("normal ex_rs1", 64'(bus_a.ex_rs1), 64'd3);
        check("normal ex_alu_op", 64'(bus_a.ex_alu_op), 64'h2);
        check("normal ex_imm", 64'(bus_a.ex_imm), 64'h10);

        // Load-use: one bubble, then the dependent instruction enters EX.
        set_load(5'd7); step();
        dependent_on7(); settle();
        check("lu hazard", 64'(haz_a), 64'd1);
        check("lu stall", 64'(stall_a), 64'd1);
        tick();
        check("lu bubble valid", 64'(bus_a.ex_valid), 64'd0);
        check("lu bubble mem_read", 64'(bus_a.ex_mem_read), 64'd0);
        check("lu bubble_cnt", 64'(cnt_a), 64'd1);
        settle();
        check("lu cleared", 64'(haz_a), 64'd0);
        tick();
        check("lu dep valid", 64'(bus_a.ex_valid), 64'd1);
        check("lu dep rs2", 64'(bus_a.ex_rs2), 64'd7);

        // Loads that must not stall: into x0, and a source that is not read.
        set_load(5'd0); step();
        rand_in(); bus_a.in_valid = 1'b1; bus_a.in_rs1 = 5'd0;
        bus_a.in_uses_rs1 = 1'b1; bus_a.in_uses_rs2 = 1'b0;
        settle();
        check("x0 hazard", 64'(haz_a), 64'd0);
        tick();
        check("x0 no bubble", 64'(bus_a.ex_valid), 64'd1);
        set_load(5'd7); step();
        rand_in(); bus_a.in_valid = 1'b1; bus_a.in_rs1 = 5'd7;
        bus_a.in_uses_rs1 = 1'b0; bus_a.in_uses_rs2 = 1'b0;
        settle();
        check("unused hazard", 64'(haz_a), 64'd0);
        tick();
        check("unused bubble_cnt", 64'(cnt_a), 64'd1);

        // Flush wins over stall and hazard; stall alone holds everything.
        set_load(5'd7); step();
        dependent_on7(); flush = 1'b1; ext_stall = 1'b1; settle();
        check("prio hazard", 64'(haz_a), 64'd1);
        check("prio stall", 64'(stall_a), 64'd0);
        tick();
        check("prio flushed", 64'(bus_a.ex_valid), 64'd0);
        check("prio bubble_cnt", 64'(cnt_a), 64'd1);
        set_load(5'd7); step();
        dependent_on7(); ext_stall = 1'b1; settle();
        check("hold stall", 64'(stall_a), 64'd1);
        tick();
        check("hold valid", 64'(bus_a.ex_valid), 64'd1);
        check("hold rd", 64'(bus_a.ex_rd), 64'd7);
        check("hold bubble_cnt", 64'(cnt_a), 64'd1);

        // Five load-use bubbles from a fresh reset: the 2-bit counter sticks at 3.
        rst_n = 1'b0; rand_in(); tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            set_load(5'd7); bus_a.in_rs1 = 5'd7; bus_a.in_uses_rs1 = 1'b1;
            step();
            step();
            check("sat cnt2", 64'(cnt_b), 64'((k < 3) ? k : 3));
            check("sat cnt16", 64'(cnt_a), 64'(k));
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rand_in();
            flush     = 1'($urandom_range(0, 9) == 0);
            ext_stall = 1'($urandom_range(0, 4) == 0);
            rst_n     = 1'($urandom_range(0, 59) != 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage RISC-V core, with integrated load-use hazard detection and bubble insertion.
- Captures decoded operands and control from ID and presents them to EX.
- Its ex_rs1/ex_rs2/ex_rd/ex_reg_write outputs are the EX-side register indices and write enable consumed by the forwarding unit.
- Produces the stall that freezes PC and IF/ID on a load-use hazard.

Parameters:
- XLEN, 32, data/PC width
- CNT_W, 16, width of the bubble performance counter

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  ID holds a valid instruction
- in_pc  in  XLEN  PC of ID instruction
- in_rs1, in_rs2, in_rd  in  5  register indices
- in_uses_rs1, in_uses_rs2  in  1  instruction actually reads rs1/rs2
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  decoded immediate
- in_reg_write, in_mem_read, in_mem_write, in_alu_src  in  1  control bits
- in_alu_op  in  4  ALU operation
- flush  in  1  taken branch/jump resolved in EX; kill ID instruction
- ext_stall  in  1  downstream (MEM) wait; hold EX
- ex_valid  out  1  EX holds a valid instruction
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies
- ex_rs1, ex_rs2, ex_rd  out  5  registered indices
- ex_reg_write, ex_mem_read, ex_mem_write, ex_alu_src  out  1  registered control
- ex_alu_op  out  4  registered ALU op
- load_use_hazard  out  1  combinational hazard flag
- if_id_stall  out  1  freeze PC and IF/ID this cycle
- bubble_cnt  out  CNT_W  count of inserted load-use bubbles

Behaviour:
- Reset: rst_n sampled low at a rising edge zeroes every registered output, including ex_valid and bubble_cnt. Takes priority over every other input. Reset in the middle of a stall or hazard discards the held instruction.
- Hazard (combinational from current registers and inputs): load_use_hazard = ex_valid & ex_mem_read & (ex_rd != 0) & in_valid & ((in_uses_rs1 & ex_rd == in_rs1) | (in_uses_rs2 & ex_rd == in_rs2)).
- if_id_stall = ~flush & (ext_stall | load_use_hazard).
- Register update per rising edge, first match wins:
  1. !rst_n: all zero.
  2. flush: load a bubble. ex_valid=0, all control, indices and data fields 0. Applies even if ext_stall or load_use_hazard is also asserted.
  3. ext_stall: hold all registers unchanged.
  4. load_use_hazard: load a bubble. bubble_cnt += 1, saturating at 2^CNT_W-1 (no wrap).
  5. otherwise: capture all in_* fields; ex_valid = in_valid. If in_valid=0, control bits and indices load 0 (data fields may load, but zero them for determinism).
- Latency: one cycle, ID to EX.
- Load-use stall: exactly one bubble per load-use pair when ext_stall is low. On the following cycle the load has moved to MEM, the hazard clears, and the dependent instruction is captured. MEM-to-EX forwarding then supplies the operand.
- A bubble never asserts ex_reg_write, ex_mem_read or ex_mem_write. Downstream write-back and forwarding therefore never see a phantom writer.
- x0: ex_rd == 0 never raises a hazard, even for a load.
- bubble_cnt increments only under case 4; it does not count flushes or ext_stall holds.

Test Plan:
- Reset: rst_n=0 for 2 cycles with random inputs -> all outputs 0, including bubble_cnt, if_id_stall and load_use_hazard. First capture happens on the edge after rst_n=1.
- Normal flow: in_valid=1, in_rd=5, in_rs1=3, in_alu_op=4'h2, in_imm=32'h10 -> next cycle ex_valid=1, ex_rd=5, ex_rs1=3, ex_alu_op=2, ex_imm=32'h10; if_id_stall=0.
- Load-use: lw x7 in EX (ex_mem_read=1, ex_rd=7), ID has in_rs2=7, in_uses_rs2=1 -> load_use_hazard=1, if_id_stall=1. Next cycle: ex_valid=0, ex_mem_read=0, bubble_cnt=1. Cycle after: dependent instruction captured.
- Non-hazards: load with ex_rd=0 and in_rs1=0; and load with ex_rd=7, in_rs1=7, in_uses_rs1=0 -> both give load_use_hazard=0 and no bubble.
- Priority: load-use condition, ext_stall=1 and flush=1 together -> bubble loaded, if_id_stall=0, bubble_cnt unchanged. With flush=0, ext_stall=1 -> registers held, if_id_stall=1, bubble_cnt unchanged.
- Saturation: CNT_W=2, force 5 consecutive load-use bubbles -> bubble_cnt reads 1,2,3,3,3.
